// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch in T0-T2, per-opcode execute in T3-T7.
// All controls decode registered state only; IR is consulted solely on the T2->T3 edge.
module control_unit #(
    parameter int unsigned OPW = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        BAout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Read,
    output logic        Write,
    output logic        Run
);

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsLd, ClsLdi, ClsSt, ClsAlu, ClsImm, ClsMulDiv, ClsNegNot,
        ClsBr, ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsHalt
    } cls_e;

    state_e         state_q, state_d, last_step, fetch_next;
    cls_e           cls_q, cls_ir;
    logic           con_q;
    logic [OPW-1:0] opcode;
    logic           unused_ir_bits;

    assign opcode         = IR[31 -: OPW];
    assign unused_ir_bits = ^IR[31-OPW:0];

    // nop and undefined opcodes fall through to ClsNone
    always_comb begin
        cls_ir = ClsNone;
        case (opcode)
            OPW'(0):                                      cls_ir = ClsLd;
            OPW'(1):                                      cls_ir = ClsLdi;
            OPW'(2):                                      cls_ir = ClsSt;
            OPW'(3), OPW'(4), OPW'(5), OPW'(6), OPW'(7),
            OPW'(8), OPW'(9), OPW'(10), OPW'(11):         cls_ir = ClsAlu;
            OPW'(12), OPW'(13), OPW'(14):                 cls_ir = ClsImm;
            OPW'(15), OPW'(16):                           cls_ir = ClsMulDiv;
            OPW'(17), OPW'(18):                           cls_ir = ClsNegNot;
            OPW'(19):                                     cls_ir = ClsBr;
            OPW'(20):                                     cls_ir = ClsJr;
            OPW'(21):                                     cls_ir = ClsJal;
            OPW'(22):                                     cls_ir = ClsIn;
            OPW'(23):                                     cls_ir = ClsOut;
            OPW'(24):                                     cls_ir = ClsMfhi;
            OPW'(25):                                     cls_ir = ClsMflo;
            OPW'(27):                                     cls_ir = ClsHalt;
            default:                                      cls_ir = ClsNone;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StRst;
            cls_q   <= ClsNone;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StT2) cls_q <= cls_ir;
            if (state_q == StT5) con_q <= CON_FF;
        end
    end

    always_comb begin
        case (cls_q)
            ClsNegNot, ClsJal:        last_step = StT4;
            ClsAlu, ClsImm, ClsLdi:   last_step = StT5;
            ClsMulDiv, ClsBr:         last_step = StT6;
            ClsLd, ClsSt:             last_step = StT7;
            default:                  last_step = StT3;
        endcase
        // Stop only takes effect on instruction boundaries
        fetch_next = Stop ? StHalt : StT0;
        state_d    = state_q;
        case (state_q)
            StRst:  state_d = fetch_next;
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2: begin
                if (cls_ir == ClsHalt)      state_d = StHalt;
                else if (cls_ir == ClsNone) state_d = fetch_next;
                else                        state_d = StT3;
            end
            StT3:   state_d = (last_step == StT3) ? fetch_next : StT4;
            StT4:   state_d = (last_step == StT4) ? fetch_next : StT5;
            StT5:   state_d = (last_step == StT5) ? fetch_next : StT6;
            StT6:   state_d = (last_step == StT6) ? fetch_next : StT7;
            StT7:   state_d = fetch_next;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin, IncPC} = '0;
        {Gra, Grb, Grc, Rin, Rout, Read, Write} = '0;
        Run = (state_q != StRst) && (state_q != StHalt);
        case (state_q)
            StT0: {PCout, MARin, IncPC, Zin} = '1;
            StT1: {Zlowout, PCin, Read, MDRin} = '1;
            StT2: {MDRout, IRin} = '1;
            StT3: begin
                case (cls_q)
                    ClsAlu, ClsImm:        {Grb, Rout, Yin} = '1;
                    ClsLd, ClsLdi, ClsSt:  {Grb, BAout, Yin} = '1;
                    ClsMulDiv:             {Gra, Rout, Yin} = '1;
                    ClsNegNot:             {Grb, Rout, Zin} = '1;
                    ClsBr:                 {Gra, Rout, CONin} = '1;
                    ClsJr:                 {Gra, Rout, PCin} = '1;
                    ClsJal:                {PCout, Grb, Rin} = '1;
                    ClsIn:                 {InPortout, Gra, Rin} = '1;
                    ClsOut:                {Gra, Rout, OutPortin} = '1;
                    ClsMfhi:               {HIout, Gra, Rin} = '1;
                    ClsMflo:               {LOout, Gra, Rin} = '1;
                    default: ;
                endcase
            end
            StT4: begin
                case (cls_q)
                    ClsAlu:                        {Grc, Rout, Zin} = '1;
                    ClsImm, ClsLd, ClsLdi, ClsSt:  {Cout, Zin} = '1;
                    ClsMulDiv:                     {Grb, Rout, Zin} = '1;
                    ClsNegNot:                     {Zlowout, Gra, Rin} = '1;
                    ClsBr:                         {PCout, Yin} = '1;
                    ClsJal:                        {Gra, Rout, PCin} = '1;
                    default: ;
                endcase
            end
            StT5: begin
                case (cls_q)
                    ClsAlu, ClsImm, ClsLdi:  {Zlowout, Gra, Rin} = '1;
                    ClsLd, ClsSt:            {Zlowout, MARin} = '1;
                    ClsMulDiv:               {Zlowout, LOin} = '1;
                    ClsBr:                   {Cout, Zin} = '1;
                    default: ;
                endcase
            end
            StT6: begin
                case (cls_q)
                    ClsLd:     {Read, MDRin} = '1;
                    ClsSt:     {Gra, Rout, MDRin} = '1;
                    ClsMulDiv: {Zhighout, HIin} = '1;
                    ClsBr:     {Zlowout, PCin} = {2{con_q}};
                    default: ;
                endcase
            end
            StT7: begin
                case (cls_q)
                    ClsLd:   {MDRout, Gra, Rin} = '1;
                    ClsSt:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected control word per cycle,
// a negedge monitor pops and compares, and also checks that at most one bus driver is active.
module tb_control_unit;

    logic        Clock, Reset, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin, IncPC;
    logic Gra, Grb, Grc, Rin, Rout, Read, Write, Run;

    control_unit #(.OPW(5)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .BAout(BAout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Read(Read),
        .Write(Write), .Run(Run)
    );

    localparam logic [27:0] B_PCOUT = 28'd1 << 0,  B_ZHI   = 28'd1 << 1,  B_ZLO   = 28'd1 << 2;
    localparam logic [27:0] B_MDROUT = 28'd1 << 3, B_HIOUT = 28'd1 << 4,  B_LOOUT = 28'd1 << 5;
    localparam logic [27:0] B_BAOUT = 28'd1 << 6,  B_INP   = 28'd1 << 7,  B_COUT  = 28'd1 << 8;
    localparam logic [27:0] B_PCIN = 28'd1 << 9,   B_IRIN  = 28'd1 << 10, B_MARIN = 28'd1 << 11;
    localparam logic [27:0] B_MDRIN = 28'd1 << 12, B_YIN   = 28'd1 << 13, B_ZIN   = 28'd1 << 14;
    localparam logic [27:0] B_HIIN = 28'd1 << 15,  B_LOIN  = 28'd1 << 16, B_OUTP  = 28'd1 << 17;
    localparam logic [27:0] B_CONIN = 28'd1 << 18, B_INCPC = 28'd1 << 19, B_GRA   = 28'd1 << 20;
    localparam logic [27:0] B_GRB = 28'd1 << 21,   B_GRC   = 28'd1 << 22, B_RIN   = 28'd1 << 23;
    localparam logic [27:0] B_ROUT = 28'd1 << 24,  B_READ  = 28'd1 << 25, B_WRITE = 28'd1 << 26;
    localparam logic [27:0] B_RUN = 28'd1 << 27;
    localparam logic [27:0] BUS_MASK = B_PCOUT | B_ZHI | B_ZLO | B_MDROUT | B_HIOUT | B_LOOUT
                                     | B_BAOUT | B_INP | B_COUT | B_ROUT;

    localparam logic [27:0] V_T0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [27:0] V_T1 = B_RUN | B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [27:0] V_T2 = B_RUN | B_MDROUT | B_IRIN;

    logic [27:0] outs;
    assign outs = {Run, Write, Read, Rout, Rin, Grc, Grb, Gra, IncPC, CONin, OutPortin, LOin,
                   HIin, Zin, Yin, MDRin, MARin, IRin, PCin, Cout, InPortout, BAout, LOout,
                   HIout, MDRout, Zlowout, Zhighout, PCout};

    typedef struct {
        logic [27:0] v;
        string       n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Monitor: one expected control word per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            checks++;
            if ($countones(outs & BUS_MASK) > 1) begin
                errors++;
                $display("FAIL bus_onehot0 at %0t: outputs=%07h", $time, outs);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (outs !== e.v) begin
                    errors++;
                    $display("FAIL %s at %0t: got %07h expected %07h", e.n, $time, outs, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [27:0] v, input string n);
        exp_t e;
        e.v = v;
        e.n = n;
        sb.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input string n);
        IR = ir;
        step(V_T0, {n, "_t0"});
        step(V_T1, {n, "_t1"});
        step(V_T2, {n, "_t2"});
    endtask

    task automatic reset_and_start();
        Reset = 1'b0;
        step('0, "rst_hold");
        Reset = 1'b1;
        step('0, "rst_cycle");
    endtask

    initial begin
        Reset  = 1'b0;
        Stop   = 1'b0;
        CON_FF = 1'b0;
        IR     = '0;
        @(posedge Clock);
        #1;
        step('0, "rst_hold0");
        reset_and_start();

        fetch(32'h69180025, "andi");
        step(B_RUN | B_GRB | B_ROUT | B_YIN, "andi_t3");
        step(B_RUN | B_COUT | B_ZIN, "andi_t4");
        step(B_RUN | B_ZLO | B_GRA | B_RIN, "andi_t5");

        fetch(32'h00800075, "ld");
        step(B_RUN | B_GRB | B_BAOUT | B_YIN, "ld_t3");
        step(B_RUN | B_COUT | B_ZIN, "ld_t4");
        step(B_RUN | B_ZLO | B_MARIN, "ld_t5");
        step(B_RUN | B_READ | B_MDRIN, "ld_t6");
        step(B_RUN | B_MDROUT | B_GRA | B_RIN, "ld_t7");

        fetch(32'h10800090, "st");
        step(B_RUN | B_GRB | B_BAOUT | B_YIN, "st_t3");
        step(B_RUN | B_COUT | B_ZIN, "st_t4");
        step(B_RUN | B_ZLO | B_MARIN, "st_t5");
        step(B_RUN | B_GRA | B_ROUT | B_MDRIN, "st_t6");
        step(B_RUN | B_WRITE, "st_t7");

        for (int k = 0; k < 2; k++) begin
            CON_FF = (k == 0);
            fetch(32'h99900023, "br");
            step(B_RUN | B_GRA | B_ROUT | B_CONIN, "br_t3");
            step(B_RUN | B_PCOUT | B_YIN, "br_t4");
            step(B_RUN | B_COUT | B_ZIN, "br_t5");
            step((k == 0) ? (B_RUN | B_ZLO | B_PCIN) : B_RUN, "br_t6");
        end
        CON_FF = 1'b0;

        fetch(32'hD0000000, "nop");
        fetch(32'hF8000000, "undef");

        fetch(32'h78000000, "mul");
        step(B_RUN | B_GRA | B_ROUT | B_YIN, "mul_t3");
        step(B_RUN | B_GRB | B_ROUT | B_ZIN, "mul_t4");
        step(B_RUN | B_ZLO | B_LOIN, "mul_t5");
        step(B_RUN | B_ZHI | B_HIIN, "mul_t6");

        fetch(32'hC8800000, "mflo");
        step(B_RUN | B_LOOUT | B_GRA | B_RIN, "mflo_t3");

        fetch(32'hA8000000, "jal");
        step(B_RUN | B_PCOUT | B_GRB | B_RIN, "jal_t3");
        step(B_RUN | B_GRA | B_ROUT | B_PCIN, "jal_t4");

        // Stop raised mid-add: instruction completes, then HALT
        fetch(32'h18918000, "add");
        step(B_RUN | B_GRB | B_ROUT | B_YIN, "add_t3");
        Stop = 1'b1;
        step(B_RUN | B_GRC | B_ROUT | B_ZIN, "add_t4");
        step(B_RUN | B_ZLO | B_GRA | B_RIN, "add_t5");
        step('0, "stop_halt");
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) step('0, "stop_halt_hold");

        reset_and_start();
        fetch(32'hD8000000, "halt");
        for (int i = 0; i < 20; i++) step('0, "halt_hold");

        // Reset asserted inside st T7 must clear Write before the next edge
        reset_and_start();
        fetch(32'h10800090, "st2");
        step(B_RUN | B_GRB | B_BAOUT | B_YIN, "st2_t3");
        step(B_RUN | B_COUT | B_ZIN, "st2_t4");
        step(B_RUN | B_ZLO | B_MARIN, "st2_t5");
        step(B_RUN | B_GRA | B_ROUT | B_MDRIN, "st2_t6");
        #1;
        Reset = 1'b0;
        step('0, "st2_t7_async_rst");
        Reset = 1'b1;
        step('0, "post_rst_cycle");
        step(V_T0, "post_rst_t0");

        @(negedge Clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
